// File: rtl/lse_simd_sat_stage_pkg.sv
// Shared types and helpers for the SIMD log-space datapath (adder and saturation stage).
package lse_simd_pkg;

    localparam int LSE_WIDTH = 24;
    localparam int MAX_LANES = 4;

    typedef enum logic [1:0] {
        MODE_1X24 = 2'b00,
        MODE_2X12 = 2'b01,
        MODE_4X6  = 2'b10
    } simd_mode_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b10
    } skid_state_e;

    // Carry bits that belong to a live lane; the illegal mode has no live lanes.
    function automatic logic [MAX_LANES-1:0] active_carry(input logic [1:0] mode,
                                                          input logic [MAX_LANES-1:0] carry);
        case (mode)
            MODE_1X24: active_carry = {3'b000, carry[0]};
            MODE_2X12: active_carry = {2'b00, carry[1:0]};
            MODE_4X6:  active_carry = carry;
            default:   active_carry = 4'b0000;
        endcase
    endfunction

    function automatic logic [LSE_WIDTH-1:0] lane_sat_mask(input logic [1:0] mode,
                                                           input logic [MAX_LANES-1:0] carry);
        case (mode)
            MODE_1X24: lane_sat_mask = {24{carry[0]}};
            MODE_2X12: lane_sat_mask = {{12{carry[1]}}, {12{carry[0]}}};
            MODE_4X6:  lane_sat_mask = {{6{carry[3]}}, {6{carry[2]}}, {6{carry[1]}}, {6{carry[0]}}};
            default:   lane_sat_mask = 24'h000000;
        endcase
    endfunction

    function automatic logic [2:0] popcount4(input logic [MAX_LANES-1:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/lse_simd_sat_stage_if.sv
// Upstream/downstream valid-ready bus of the saturation stage.
interface lse_simd_sat_stage_if;
    import lse_simd_pkg::*;

    logic                 i_valid;
    logic                 o_ready;
    logic [LSE_WIDTH-1:0] i_result;
    logic [MAX_LANES-1:0] i_lane_carry;
    logic [1:0]           i_simd_mode;
    logic                 o_valid;
    logic                 i_ready;
    logic [LSE_WIDTH-1:0] o_data;
    logic [MAX_LANES-1:0] o_sat_mask;

    modport master (
        output i_valid, i_result, i_lane_carry, i_simd_mode, i_ready,
        input  o_ready, o_valid, o_data, o_sat_mask
    );

    modport slave (
        input  i_valid, i_result, i_lane_carry, i_simd_mode, i_ready,
        output o_ready, o_valid, o_data, o_sat_mask
    );
endinterface

// File: rtl/lse_simd_sat_stage_skid_buffer.sv
// Two-entry skid buffer: full throughput with a registered upstream ready.
module lse_skid_buffer
    import lse_simd_pkg::*;
#(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state_r, state_next_s;
    logic         ready_r, valid_r;
    logic [W-1:0] out_r, skid_r;
    logic         accept_s, xfer_s, load_out_s, load_skid_s, pop_skid_s;

    assign accept_s  = in_valid & ready_r;
    assign xfer_s    = valid_r & out_ready;
    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_data  = out_r;

    // Next-state and register-load selection for the EMPTY/ONE/FULL handshake.
    always_comb begin
        state_next_s = state_r;
        load_out_s   = 1'b0;
        load_skid_s  = 1'b0;
        pop_skid_s   = 1'b0;
        case (state_r)
            SKID_EMPTY: begin
                if (accept_s) begin
                    state_next_s = SKID_ONE;
                    load_out_s   = 1'b1;
                end else begin
                    state_next_s = SKID_EMPTY;
                end
            end
            SKID_ONE: begin
                if (accept_s && xfer_s) begin
                    state_next_s = SKID_ONE;
                    load_out_s   = 1'b1;
                end else if (accept_s) begin
                    state_next_s = SKID_FULL;
                    load_skid_s  = 1'b1;
                end else if (xfer_s) begin
                    state_next_s = SKID_EMPTY;
                end else begin
                    state_next_s = SKID_ONE;
                end
            end
            SKID_FULL: begin
                if (xfer_s) begin
                    state_next_s = SKID_ONE;
                    pop_skid_s   = 1'b1;
                end else begin
                    state_next_s = SKID_FULL;
                end
            end
            default: begin
                state_next_s = SKID_EMPTY;
            end
        endcase
    end

    // State, handshake flags and payload registers; ready/valid follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SKID_EMPTY;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            out_r   <= {W{1'b0}};
            skid_r  <= {W{1'b0}};
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != SKID_FULL);
            valid_r <= (state_next_s != SKID_EMPTY);
            if (load_out_s) begin
                out_r <= in_data;
            end else if (pop_skid_s) begin
                out_r <= skid_r;
            end
            if (load_skid_s) begin
                skid_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/lse_simd_sat_stage.sv
// Clamps overflowed log-space lanes to all ones, buffers the result and keeps saturation statistics.
module lse_simd_sat_stage
    import lse_simd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear_stats,
    lse_simd_sat_stage_if.slave    bus,
    output logic [CNT_W-1:0]       o_sat_count,
    output logic [MAX_LANES-1:0]   o_sticky_ovf,
    output logic                   o_mode_err
);

    localparam int PAY_W = LSE_WIDTH + MAX_LANES;

    logic [MAX_LANES-1:0] act_mask_s;
    logic [LSE_WIDTH-1:0] sat_data_s;
    logic [PAY_W-1:0]     in_payload_s, out_payload_s;
    logic                 accept_s, mode_illegal_s;
    logic [2:0]           pop_s;
    logic [CNT_W:0]       cnt_sum_s;

    assign act_mask_s     = active_carry(bus.i_simd_mode, bus.i_lane_carry);
    assign sat_data_s     = bus.i_result | lane_sat_mask(bus.i_simd_mode, bus.i_lane_carry);
    assign in_payload_s   = {act_mask_s, sat_data_s};
    assign mode_illegal_s = (bus.i_simd_mode == 2'b11);
    assign accept_s       = bus.i_valid & bus.o_ready;
    assign pop_s          = popcount4(act_mask_s);
    assign cnt_sum_s      = {1'b0, o_sat_count} + {{(CNT_W-2){1'b0}}, pop_s};

    lse_skid_buffer #(.W(PAY_W)) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .in_valid  (bus.i_valid),
        .in_ready  (bus.o_ready),
        .in_data   (in_payload_s),
        .out_valid (bus.o_valid),
        .out_ready (bus.i_ready),
        .out_data  (out_payload_s)
    );

    assign bus.o_data     = out_payload_s[LSE_WIDTH-1:0];
    assign bus.o_sat_mask = out_payload_s[PAY_W-1:LSE_WIDTH];

    // Statistics: clear wins over a same-cycle accept; the counter sticks at its maximum.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_stats) begin
            o_sat_count  <= {CNT_W{1'b0}};
            o_sticky_ovf <= {MAX_LANES{1'b0}};
            o_mode_err   <= 1'b0;
        end else if (accept_s) begin
            o_sat_count  <= cnt_sum_s[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_s[CNT_W-1:0];
            o_sticky_ovf <= o_sticky_ovf | act_mask_s;
            o_mode_err   <= o_mode_err | mode_illegal_s;
        end
    end

endmodule

// File: tb/tb_lse_simd_sat_stage.sv
// Self-checking bench: directed vectors, backpressure/saturation/clear/reset sequences, random traffic vs. a queue model.
module tb_lse_simd_sat_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] sat_count;
    logic [3:0]  sticky;
    logic        mode_err;

    int checks = 0;
    int errors = 0;

    lse_simd_sat_stage_if bus ();

    lse_simd_sat_stage #(.CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clear_stats (clear),
        .bus           (bus),
        .o_sat_count   (sat_count),
        .o_sticky_ovf  (sticky),
        .o_mode_err    (mode_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [27:0] mq[$];
    bit          m_ready = 1'b0;
    int          m_count = 0;
    logic [3:0]  m_sticky = 4'b0000;
    bit          m_err = 1'b0;
    bit          last_acc, last_xfer;
    logic [23:0] last_rx;

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] result;
        logic [3:0]  carry;
        logic [23:0] exp_data;
        logic [3:0]  exp_mask;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lane count from mode, then each overflowed lane's bit range ORed with ones.
    function automatic logic [27:0] ref_sat(input logic [1:0] mode, input logic [23:0] res,
                                            input logic [3:0] carry);
        int lanes;
        int w;
        logic [23:0] d;
        logic [3:0]  m;
        lanes = (mode == 2'd0) ? 1 : (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 0;
        w = (lanes == 0) ? 0 : 24 / lanes;
        d = res;
        m = 4'b0000;
        for (int k = 0; k < lanes; k++) begin
            if (carry[k]) begin
                m[k] = 1'b1;
                d = d | 24'(((64'd1 << w) - 64'd1) << (k * w));
            end
        end
        return {m, d};
    endfunction

    task automatic cycle();
        bit xfer;
        bit acc;
        logic [27:0] p;
        int pc;
        xfer = (mq.size() > 0) && bus.i_ready;
        acc  = bus.i_valid && m_ready;
        last_acc  = acc && !rst;
        last_xfer = xfer && !rst;
        last_rx   = bus.o_data;
        if (rst) begin
            mq.delete();
            m_ready = 1'b0; m_count = 0; m_sticky = 4'b0000; m_err = 1'b0;
        end else begin
            if (xfer) void'(mq.pop_front());
            p = ref_sat(bus.i_simd_mode, bus.i_result, bus.i_lane_carry);
            if (acc) mq.push_back(p);
            m_ready = (mq.size() < 2);
            if (clear) begin
                m_count = 0; m_sticky = 4'b0000; m_err = 1'b0;
            end else if (acc) begin
                pc = 0;
                for (int k = 0; k < 4; k++) pc += int'(p[24+k]);
                m_count = (m_count + pc > 65535) ? 65535 : m_count + pc;
                m_sticky |= p[27:24];
                if (bus.i_simd_mode == 2'b11) m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("ready", {31'd0, bus.o_ready}, {31'd0, m_ready});
        check("valid", {31'd0, bus.o_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("data", {8'd0, bus.o_data}, {8'd0, mq[0][23:0]});
            check("mask", {28'd0, bus.o_sat_mask}, {28'd0, mq[0][27:24]});
        end
        check("count", {16'd0, sat_count}, m_count);
        check("sticky", {28'd0, sticky}, {28'd0, m_sticky});
        check("mode_err", {31'd0, mode_err}, {31'd0, m_err});
    endtask

    task automatic drive(input bit v, input logic [1:0] mode, input logic [23:0] res, input logic [3:0] carry);
        bus.i_valid = v; bus.i_simd_mode = mode; bus.i_result = res; bus.i_lane_carry = carry;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.o_ready}, 32'd0);
        check("rst_data", {8'd0, bus.o_data}, 32'd0);
        check("rst_mask", {28'd0, bus.o_sat_mask}, 32'd0);
        check("rst_count", {16'd0, sat_count}, 32'd0);
        check("rst_sticky", {28'd0, sticky}, 32'd0);
        check("rst_err", {31'd0, mode_err}, 32'd0);
        rst = 1'b0;
        cycle();
        check("post_rst_ready", {31'd0, bus.o_ready}, 32'd1);
    endtask

    initial begin
        int sent;
        int got;
        logic [23:0] rx[$];

        vecs[0] = '{2'b01, 24'h123ABC, 4'b0010, 24'hFFFABC, 4'b0010};
        vecs[1] = '{2'b10, 24'h000000, 4'b1011, 24'hFC0FFF, 4'b1011};
        vecs[2] = '{2'b00, 24'h5A5A5A, 4'b0100, 24'h5A5A5A, 4'b0000};
        vecs[3] = '{2'b00, 24'h000001, 4'b0001, 24'hFFFFFF, 4'b0001};
        vecs[4] = '{2'b11, 24'hABCDEF, 4'b1111, 24'hABCDEF, 4'b0000};
        vecs[5] = '{2'b01, 24'h000000, 4'b1101, 24'h000FFF, 4'b0001};
        vecs[6] = '{2'b10, 24'h123456, 4'b0100, 24'h13F456, 4'b0100};

        bus.i_ready = 1'b1;
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        do_reset();

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].result, vecs[i].carry);
            cycle();
            check("vec_data", {8'd0, bus.o_data}, {8'd0, vecs[i].exp_data});
            check("vec_mask", {28'd0, bus.o_sat_mask}, {28'd0, vecs[i].exp_mask});
            if (i == 0) begin
                check("vec0_count", {16'd0, sat_count}, 32'd1);
                check("vec0_sticky", {28'd0, sticky}, 32'h2);
            end
        end
        check("vec_mode_err", {31'd0, mode_err}, 32'd1);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        cycle();

        // Backpressure: 8 beats, downstream stalls after the first
        sent = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            drive(sent < 8, 2'b00, 24'h100000 + 24'(sent), 4'h0);
            bus.i_ready = (c == 0) || (c >= 6);
            cycle();
            if (last_acc) sent++;
            if (last_xfer) begin
                rx.push_back(last_rx);
                got++;
            end
            if (c == 3) check("bp_ready_low", {31'd0, bus.o_ready}, 32'd0);
        end
        check("bp_received", got, 32'd8);
        for (int i = 0; i < rx.size(); i++) check("bp_order", {8'd0, rx[i]}, 32'h100000 + i);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        bus.i_ready = 1'b1;
        cycle();

        // Counter saturation
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            drive(1'b1, 2'b10, 24'($urandom), 4'b1111);
            cycle();
        end
        check("sat_stick", {16'd0, sat_count}, 32'h0000FFFF);

        // Clear in the same cycle as an accept
        drive(1'b1, 2'b10, 24'h000000, 4'b0001);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        check("clr_count", {16'd0, sat_count}, 32'd0);
        check("clr_sticky", {28'd0, sticky}, 32'd0);
        check("clr_mask", {28'd0, bus.o_sat_mask}, 32'h1);
        check("clr_data", {8'd0, bus.o_data}, 32'h00003F);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 24'($urandom), 4'($urandom));
            bus.i_ready = $urandom_range(0, 2) != 0;
            clear = $urandom_range(0, 15) == 0;
            cycle();
        end
        clear = 1'b0;

        // Reset with two beats buffered
        bus.i_ready = 1'b0;
        drive(1'b1, 2'b11, 24'h0ABCDE, 4'b1000);
        cycle();
        cycle();
        cycle();
        check("pre_rst_full", {31'd0, bus.o_ready}, 32'd0);
        drive(1'b0, 2'b00, 24'h0, 4'h0);
        bus.i_ready = 1'b1;
        do_reset();
        check("post_rst_valid", {31'd0, bus.o_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
